// File: rtl/cp0_int_pkg.sv
// Shared constants for the CP0 Count/Compare timer and interrupt-pending unit:
// mtc0 select codes, Cause.IP field layout and the Cause.TI bit index.
package cp0_int_pkg;

  localparam logic [2:0] SEL_COUNT = 3'd0;
  localparam logic [2:0] SEL_CMP0  = 3'd1;
  localparam logic [2:0] SEL_PEND  = 3'd6;
  localparam logic [2:0] SEL_SWINT = 3'd7;

  localparam int IP7_BIT      = 7;
  localparam int IP6_IP2_BITS = 2;  // lsb of the five hardware-sampled lines
  localparam int IP1_IP0_BITS = 0;  // lsb of the two software bits
  localparam int CAUSE_TI_BIT = 30;

  localparam int MAX_TIMERS = 4;

  typedef struct packed {
    logic       ip7;
    logic [4:0] ip_hw;
    logic [1:0] ip_sw;
  } cause_ip_t;

endpackage

// File: rtl/cp0_int_timer_if.sv
// mtc0/mfc0 access port from the MEM stage into the CP0 timer block.
interface cp0_int_timer_if;
  logic        wen;
  logic [2:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wen, output sel, output wdata, input rdata);
  modport slave  (input wen, input sel, input wdata, output rdata);
endinterface

// File: rtl/cp0_timer_chan.sv
// One Compare channel: Compare register plus a sticky pending flag that a
// Compare write clears and a non-zero Count==Compare match sets.
module cp0_timer_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] count,
  input  logic        wen_cmp,
  input  logic [31:0] wdata,
  output logic [31:0] compare,
  output logic        pend
);

  logic [31:0] cmp_r;
  logic        pend_r;

  // Compare register and sticky pend; a write in the match cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_r  <= 32'd0;
      pend_r <= 1'b0;
    end else if (wen_cmp) begin
      cmp_r  <= wdata;
      pend_r <= 1'b0;
    end else if ((cmp_r != 32'd0) && (count == cmp_r)) begin
      pend_r <= 1'b1;
    end
  end

  assign compare = cmp_r;
  assign pend    = pend_r;

endmodule

// File: rtl/cp0_int_timer.sv
// CP0 Count/Compare timer and Cause.IP/TI interrupt-pending unit.
// Define CP0_INT_SYNC_EN to pass ext_int through a 2-flop synchroniser.
module cp0_int_timer
  import cp0_int_pkg::*;
#(
  parameter int NUM_TIMERS = 1,
  parameter int COUNT_DIV  = 2,
  parameter int EXT_INT_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXT_INT_W-1:0] ext_int,
  input  logic                 stall,
  cp0_int_timer_if.slave       bus,
  input  logic [7:0]           status_im,
  input  logic                 status_ie,
  input  logic                 status_exl,
  output logic [7:0]           cause_ip,
  output logic                 cause_ti,
  output logic                 int_req
);

  localparam logic [4:0] PCNT_MAX = 5'(COUNT_DIV - 1);

  logic [4:0]      pcnt_r;
  logic [31:0]     count_r;
  logic            cnt_wen_s;
  logic [31:0]     cmp_s [MAX_TIMERS];
  logic [3:0]      pend_s;
  logic [5:0]      ext_pad_s;
  logic [5:0]      ext_smp_s;
  logic [5:0]      ip_ext_r;
  logic [1:0]      ip_sw_r;
  cause_ip_t       cause_s;
  logic            int_req_r;
  logic [31:0]     rdata_s;

  assign cnt_wen_s = bus.wen && (bus.sel == SEL_COUNT);

  // Count and prescaler; a Count write restarts the prescaler phase
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
      pcnt_r  <= 5'd0;
    end else if (cnt_wen_s) begin
      count_r <= bus.wdata;
      pcnt_r  <= 5'd0;
    end else if (pcnt_r == PCNT_MAX) begin
      count_r <= count_r + 32'd1;
      pcnt_r  <= 5'd0;
    end else begin
      pcnt_r  <= pcnt_r + 5'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_TIMERS; gi++) begin : g_chan
      if (gi < NUM_TIMERS) begin : g_on
        cp0_timer_chan u_chan (
          .clk     (clk),
          .rst     (rst),
          .count   (count_r),
          .wen_cmp (bus.wen && (bus.sel == 3'(gi + 1))),
          .wdata   (bus.wdata),
          .compare (cmp_s[gi]),
          .pend    (pend_s[gi])
        );
      end else begin : g_off
        assign cmp_s[gi]  = 32'd0;
        assign pend_s[gi] = 1'b0;
      end
    end
  endgenerate

  // With five lines the IP7 external contribution is a constant zero
  assign ext_pad_s = 6'(ext_int);

`ifdef CP0_INT_SYNC_EN
  logic [5:0] sync1_r;
  logic [5:0] sync2_r;

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 6'd0;
      sync2_r <= 6'd0;
    end else begin
      sync1_r <= ext_pad_s;
      sync2_r <= sync1_r;
    end
  end

  assign ext_smp_s = sync2_r;
`else
  assign ext_smp_s = ext_pad_s;
`endif

  // Hardware IP lines freeze under stall; software IP bits only via mtc0
  always_ff @(posedge clk) begin
    if (rst) begin
      ip_ext_r <= 6'd0;
      ip_sw_r  <= 2'd0;
    end else begin
      if (!stall) begin
        ip_ext_r <= ext_smp_s;
      end
      if (bus.wen && (bus.sel == SEL_SWINT)) begin
        ip_sw_r <= bus.wdata[9:8];
      end
    end
  end

  assign cause_ti = |pend_s;
  assign cause_s  = '{ip7: cause_ti | ip_ext_r[5], ip_hw: ip_ext_r[4:0], ip_sw: ip_sw_r};
  assign cause_ip = cause_s;

  // Registered request towards the MEM-stage exception logic
  always_ff @(posedge clk) begin
    if (rst) begin
      int_req_r <= 1'b0;
    end else begin
      int_req_r <= status_ie & ~status_exl & (|(cause_s & status_im));
    end
  end

  assign int_req = int_req_r;

  // mfc0 read mux; absent channels decode to zero through cmp_s
  always_comb begin
    rdata_s = 32'd0;
    case (bus.sel)
      SEL_COUNT:                rdata_s = count_r;
      3'd1, 3'd2, 3'd3, 3'd4:   rdata_s = cmp_s[2'(bus.sel - SEL_CMP0)];
      SEL_PEND:                 rdata_s = {28'd0, pend_s};
      SEL_SWINT:                rdata_s = {22'd0, ip_sw_r, 8'd0};
      default:                  rdata_s = 32'd0;
    endcase
  end

  assign bus.rdata = rdata_s;

endmodule

// File: tb/tb_cp0_int_timer.sv
// Randomised bench for cp0_int_timer with a count-from-elapsed-cycles reference
// model, plus directed scenarios for matches, wrap, stall, masking and channels.
module tb_cp0_int_timer;

  localparam int NT  = 3;
  localparam int DIV = 2;
  localparam int EW  = 6;
`ifdef CP0_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [EW-1:0] ext_int;
  logic          stall;
  logic [7:0]    status_im;
  logic          status_ie;
  logic          status_exl;
  logic [7:0]    cause_ip;
  logic          cause_ti;
  logic          int_req;

  int n_checks = 0;
  int n_errors = 0;

  cp0_int_timer_if bus ();

  cp0_int_timer #(.NUM_TIMERS(NT), .COUNT_DIV(DIV), .EXT_INT_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_int    (ext_int),
    .stall      (stall),
    .bus        (bus),
    .status_im  (status_im),
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .cause_ip   (cause_ip),
    .cause_ti   (cause_ti),
    .int_req    (int_req)
  );

  always #5 clk = ~clk;

  // Reference model: Count is the last written base plus elapsed cycles / DIV
  logic [31:0] m_base;
  int unsigned m_cyc;
  logic [31:0] m_cmp [NT];
  logic [NT-1:0] m_pend;
  logic [5:0]  m_ip_ext;
  logic [1:0]  m_sw;
  logic        m_ireq;
`ifdef CP0_INT_SYNC_EN
  logic [5:0]  m_dly [2];
`endif

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / DIV);
  endfunction

  function automatic logic [7:0] m_cause();
    return {(|m_pend) | m_ip_ext[5], m_ip_ext[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] s);
    int k;
    k = int'(s);
    if (k == 0) return m_count();
    else if (k >= 1 && k <= NT) return m_cmp[k-1];
    else if (k == 6) return 32'(m_pend);
    else if (k == 7) return {22'd0, m_sw, 8'd0};
    else return 32'd0;
  endfunction

  task automatic model_edge();
    logic [31:0] cnt_pre;
    logic        ireq_n;
    if (rst) begin
      m_base = 32'd0; m_cyc = 0; m_pend = '0; m_ip_ext = 6'd0; m_sw = 2'd0; m_ireq = 1'b0;
      for (int i = 0; i < NT; i++) m_cmp[i] = 32'd0;
`ifdef CP0_INT_SYNC_EN
      m_dly[0] = 6'd0; m_dly[1] = 6'd0;
`endif
    end else begin
      ireq_n  = status_ie & ~status_exl & (|(m_cause() & status_im));
      cnt_pre = m_count();
      for (int i = 0; i < NT; i++) begin
        if (bus.wen && int'(bus.sel) == i + 1) begin
          m_cmp[i] = bus.wdata; m_pend[i] = 1'b0;
        end else if (m_cmp[i] != 32'd0 && cnt_pre == m_cmp[i]) begin
          m_pend[i] = 1'b1;
        end
      end
      if (bus.wen && bus.sel == 3'd0) begin
        m_base = bus.wdata; m_cyc = 0;
      end else begin
        m_cyc++;
      end
      if (bus.wen && bus.sel == 3'd7) m_sw = bus.wdata[9:8];
`ifdef CP0_INT_SYNC_EN
      if (!stall) m_ip_ext = m_dly[1];
      m_dly[1] = m_dly[0];
      m_dly[0] = 6'(ext_int);
`else
      if (!stall) m_ip_ext = 6'(ext_int);
`endif
      m_ireq = ireq_n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_value("cause_ip", 32'(cause_ip), 32'(m_cause()));
    check_value("cause_ti", 32'(cause_ti), 32'(|m_pend));
    check_value("int_req", 32'(int_req), 32'(m_ireq));
    check_value("rdata", bus.rdata, m_read(bus.sel));
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] d);
    bus.wen = 1'b1; bus.sel = s; bus.wdata = d;
    tick();
    bus.wen = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; bus.wen = 1'b0; bus.sel = 3'd0; bus.wdata = 32'd0;
    ext_int = '0; stall = 1'b0; status_im = 8'd0; status_ie = 1'b0; status_exl = 1'b0;
    tick(); tick();
    check_value("rst_cause_ip", 32'(cause_ip), 32'd0);
    check_value("rst_int_req", 32'(int_req), 32'd0);
    check_value("rst_count", bus.rdata, 32'd0);
    rst = 1'b0;

    // Timer match on channel 0 and clear by Compare rewrite
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd5);
    status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0; bus.sel = 3'd6;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (cause_ti) found = 1'b1;
    end
    check_value("ti_rise", 32'(cause_ti), 32'd1);
    check_value("pend_mask0", bus.rdata, 32'd1);
    tick();
    check_value("int_req_rise", 32'(int_req), 32'd1);
    wr(3'd1, 32'd100);
    check_value("ti_clear", 32'(cause_ip[7]), 32'd0);

    // Compare write in the cycle Count equals the old Compare
    wr(3'd2, 32'd40);
    wr(3'd0, 32'd38);
    for (int k = 0; k < 20 && m_count() != 32'd40; k++) tick();
    wr(3'd2, 32'd1000);
    repeat (4) tick();
    bus.sel = 3'd6;
    tick();
    check_value("cmp_vs_match", bus.rdata, 32'd0);

    // Count wrap, and a Count write landing on the prescaler wrap edge
    wr(3'd0, 32'hFFFF_FFFF);
    check_value("count_load", bus.rdata, 32'hFFFF_FFFF);
    tick(); tick();
    check_value("count_wrap", bus.rdata, 32'd0);
    tick();
    wr(3'd0, 32'h0000_ABCD);
    check_value("count_wr_on_wrap", bus.rdata, 32'h0000_ABCD);

    // External line latency, then hold under stall
    ext_int = 6'b001000;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check_value("ext_lat", 32'(cause_ip[5]), 32'(k == LAT));
    end
    ext_int = 6'b000100; stall = 1'b1;
    repeat (3) tick();
    check_value("stall_hold", 32'(cause_ip[4]), 32'd0);
    stall = 1'b0;
    tick();
    check_value("stall_release", 32'(cause_ip[4]), 32'd1);

    // Software interrupt masked by EXL
    ext_int = '0;
    repeat (LAT + 1) tick();
    status_im = 8'h01; status_ie = 1'b1; status_exl = 1'b1;
    wr(3'd7, 32'h0000_0100);
    check_value("sw_ip0", 32'(cause_ip[0]), 32'd1);
    tick();
    check_value("mask_exl", 32'(int_req), 32'd0);
    status_exl = 1'b0;
    tick();
    check_value("exl_clear", 32'(int_req), 32'd1);

    // Third channel, pend mask readback and unimplemented select
    wr(3'd3, 32'd7);
    wr(3'd0, 32'd5);
    bus.sel = 3'd6;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bus.rdata == 32'd4) found = 1'b1;
    end
    check_value("pend_ch2", bus.rdata, 32'd4);
    bus.sel = 3'd5;
    tick();
    check_value("sel5_read", bus.rdata, 32'd0);
    wr(3'd5, 32'hDEAD_BEEF);
    check_value("sel5_write", bus.rdata, 32'd0);
    wr(3'd6, 32'd0);
    check_value("pend_ro", bus.rdata, 32'd4);

    // Reset mid-count restarts the prescaler phase
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.sel = 3'd0;
    tick();
    check_value("rst_phase0", bus.rdata, 32'd0);
    tick();
    check_value("rst_phase1", bus.rdata, 32'd1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      bus.wen    = ($urandom_range(0, 3) == 0);
      bus.sel    = 3'($urandom_range(0, 7));
      if (bus.sel >= 3'd1 && bus.sel <= 3'd3)
        bus.wdata = ($urandom_range(0, 9) == 0) ? 32'd0 : m_count() + 32'($urandom_range(0, 8));
      else if (bus.sel == 3'd0)
        bus.wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 50));
      else
        bus.wdata = $urandom;
      ext_int    = EW'($urandom);
      stall      = ($urandom_range(0, 2) == 0);
      status_im  = 8'($urandom);
      status_ie  = ($urandom_range(0, 3) != 0);
      status_exl = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
